// File: rtl/vga_timing.sv
// VGA timing generator: free-running h/v counters feeding the pixel generators,
// plus a single output register that keeps rgb, hsync, vsync and frame_start aligned.
module vga_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] rgb_in,
    output logic [9:0] col,
    output logic [9:0] row,
    output logic       valid,
    output logic       hsync,
    output logic       vsync,
    output logic [5:0] rgb,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic [5:0] rgb_q, rgb_d;
    logic       frame_start_q, frame_start_d;

    logic       h_wrap;
    logic       v_wrap;
    logic       h_vis;
    logic       v_vis;
    logic       vis;
    logic       hs_n;
    logic       vs_n;

    // Counter advance; >= keeps the counters bounded even from a corrupted state
    always_comb begin
        h_wrap  = (h_cnt_q >= H_MAX);
        v_wrap  = (v_cnt_q >= V_MAX);
        h_cnt_d = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = v_wrap ? 10'd0 : v_cnt_q + 10'd1;
        end
    end

    always_comb begin
        h_vis = (h_cnt_q < H_VIS);
        v_vis = (v_cnt_q < V_VIS);
        vis   = h_vis && v_vis;
        hs_n  = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
        vs_n  = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
    end

    // Stage-1 inputs: generator colour is sampled on the same edge as its counters
    always_comb begin
        hsync_d       = hs_n;
        vsync_d       = vs_n;
        rgb_d         = vis ? rgb_in : 6'b000000;
        frame_start_d = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= 10'd0;
            v_cnt_q <= 10'd0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            rgb_q         <= 6'b000000;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            rgb_q         <= rgb_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign col         = h_cnt_q;
    assign row         = v_cnt_q;
    assign valid       = vis;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign rgb         = rgb_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench for vga_timing on a scaled-down 30x15 raster
// so that several full frames fit in a short run.
module tb_vga_timing;

    localparam int HA = 16;
    localparam int HF = 4;
    localparam int HS = 6;
    localparam int HB = 4;
    localparam int VA = 8;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int HT = 30;
    localparam int VT = 15;
    localparam int FRAME = 450;

    typedef struct packed {
        logic [9:0] col;
        logic [9:0] row;
        logic       valid;
        logic       hs;
        logic       vs;
        logic [5:0] rgb;
        logic       fs;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [5:0] rgb_in;
    logic [9:0] col;
    logic [9:0] row;
    logic       valid;
    logic       hsync;
    logic       vsync;
    logic [5:0] rgb;
    logic       frame_start;

    int   mode;
    int   t;
    int   n_checks;
    int   n_fail;
    exp_t q[$];

    vga_timing #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rgb_in(rgb_in),
        .col(col),
        .row(row),
        .valid(valid),
        .hsync(hsync),
        .vsync(vsync),
        .rgb(rgb),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pixel generator stand-in, combinational on the DUT's col
    always_comb begin
        rgb_in = 6'h3F;
        if (mode == 0) rgb_in = 6'b110000;
        else if (mode == 1) rgb_in = col[5:0];
    end

    function automatic logic [9:0] hpos(int p);
        return 10'(p % HT);
    endfunction

    function automatic logic [9:0] vpos(int p);
        return 10'((p / HT) % VT);
    endfunction

    function automatic logic vis(int p);
        return (hpos(p) < 10'(HA)) && (vpos(p) < 10'(VA));
    endfunction

    function automatic logic [5:0] src(int m, int p);
        logic [9:0] h;
        h = hpos(p);
        if (m == 0) return 6'b110000;
        if (m == 1) return h[5:0];
        return 6'h3F;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: t counts pixels elapsed since reset release
    always @(posedge clk) begin
        exp_t e;
        int   p;
        int   h;
        int   v;
        if (!rst_n) begin
            t = 0;
            e = '{col: 10'd0, row: 10'd0, valid: 1'b1, hs: 1'b1,
                  vs: 1'b1, rgb: 6'd0, fs: 1'b0};
        end else begin
            p = t;
            t = t + 1;
            h = int'(hpos(p));
            v = int'(vpos(p));
            e.col   = hpos(t);
            e.row   = vpos(t);
            e.valid = vis(t);
            e.hs    = !(h >= HA + HF && h < HA + HF + HS);
            e.vs    = !(v >= VA + VF && v < VA + VF + VS);
            e.rgb   = vis(p) ? src(mode, p) : 6'd0;
            e.fs    = (h == 0) && (v == 0);
        end
        q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("col", 32'(col), 32'(e.col));
            check("row", 32'(row), 32'(e.row));
            check("valid", 32'(valid), 32'(e.valid));
            check("hsync", 32'(hsync), 32'(e.hs));
            check("vsync", 32'(vsync), 32'(e.vs));
            check("rgb", 32'(rgb), 32'(e.rgb));
            check("frame_start", 32'(frame_start), 32'(e.fs));
        end
    end

    // Pulse widths and frame period measured directly on the pins
    int hs_run;
    int vs_run;
    int fs_gap;
    bit fs_seen;

    always @(negedge clk) begin
        if (!rst_n) begin
            hs_run  = 0;
            vs_run  = 0;
            fs_gap  = 0;
            fs_seen = 0;
        end else begin
            if (!hsync) hs_run++;
            else if (hs_run > 0) begin
                check("hsync_width", 32'(hs_run), 32'(HS));
                hs_run = 0;
            end
            if (!vsync) vs_run++;
            else if (vs_run > 0) begin
                check("vsync_width", 32'(vs_run), 32'(VS * HT));
                vs_run = 0;
            end
            if (fs_seen) fs_gap++;
            if (frame_start) begin
                if (fs_seen) check("frame_period", 32'(fs_gap), 32'(FRAME));
                fs_seen = 1;
                fs_gap  = 0;
            end
        end
    end

    task automatic seek(int h, int v);
        bit found;
        found = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (int'(hpos(t)) == h && int'(vpos(t)) == v) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("seek_position", 32'(found), 32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        t        = 0;
        mode     = 2;
        rst_n    = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b1;
        mode = 0;
        repeat (FRAME) @(negedge clk);
        mode = 1;
        repeat (FRAME + 10) @(negedge clk);
        mode = 2;

        // Async reset inside hsync: pins must clear without a clock edge
        seek(HA + HF + 2, 5);
        check("pre_hsync_low", 32'(hsync), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async_hsync", 32'(hsync), 32'd1);
        check("async_vsync", 32'(vsync), 32'd1);
        check("async_rgb", 32'(rgb), 32'd0);
        check("async_col", 32'(col), 32'd0);
        check("async_row", 32'(row), 32'd0);
        check("async_valid", 32'(valid), 32'd1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (FRAME + 50) @(negedge clk);

        // Async reset while an active pixel is on the pins
        seek(7, 3);
        check("pre_rgb_active", 32'(rgb), 32'h3F);
        #2 rst_n = 1'b0;
        #1;
        check("async_rgb_active", 32'(rgb), 32'd0);
        check("async_fs", 32'(frame_start), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (100) @(negedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
